// File: rtl/arbiter_round_robin.sv
// rtl/arbiter_round_robin.sv - registered round-robin arbiter with valid/ready grant handshake
//
// Purpose: picks one of WIDTH requesters in rotating priority order and
// holds the one-hot grant until downstream accepts it. After each accepted
// grant the priority pointer moves just past the winner. Arbitration is then
// redone in the same cycle, so an accepted grant can be followed by a new
// grant on the very next cycle.
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   req      in   WIDTH  request vector, bit i = requester i wants service
//   gnt      out  WIDTH  registered one-hot grant, zero when idle
//   gnt_vld  out  1      grant valid (== |gnt)
//   gnt_rdy  in   1      downstream accepts the current grant

module arbiter_round_robin #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic             gnt_vld,
    input  logic             gnt_rdy
);

    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam logic [WIDTH_LOG:0]   WIDTH_W  = (WIDTH_LOG + 1)'(WIDTH);
    localparam logic [WIDTH_LOG-1:0] LAST_IDX = WIDTH_LOG'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     gnt_q, gnt_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;

    logic                 hs;
    logic [WIDTH_LOG-1:0] gnt_idx;
    logic [WIDTH_LOG-1:0] ptr_adv;
    logic [WIDTH_LOG-1:0] arb_ptr;
    logic [WIDTH-1:0]     arb_gnt;
    logic                 arb_found;
    logic [WIDTH_LOG:0]   arb_sum;

    assign hs = (state_q == GRANT) && gnt_rdy;

    // Index of the currently held grant; gnt_q is one-hot whenever it is used.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = WIDTH_LOG'(i);
            end
        end
    end

    // Explicit wrap keeps the pointer below WIDTH for non-power-of-two sizes.
    assign ptr_adv = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    // On an accepted grant, rearbitrate immediately from the advanced pointer.
    assign arb_ptr = hs ? ptr_adv : ptr_q;

    // Scan requesters starting at arb_ptr, wrapping modulo WIDTH; the first hit wins.
    always_comb begin
        arb_gnt   = '0;
        arb_found = 1'b0;
        arb_sum   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            arb_sum = {1'b0, arb_ptr} + (WIDTH_LOG + 1)'(k);
            if (arb_sum >= WIDTH_W) begin
                arb_sum = arb_sum - WIDTH_W;
            end
            if (!arb_found && req[arb_sum[WIDTH_LOG-1:0]]) begin
                arb_gnt[arb_sum[WIDTH_LOG-1:0]] = 1'b1;
                arb_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = GRANT;
                    gnt_d   = arb_gnt;
                end
            end
            GRANT: begin
                // Without a handshake the grant is frozen regardless of req.
                if (hs) begin
                    ptr_d = ptr_adv;
                    if (arb_found) begin
                        gnt_d = arb_gnt;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        gnt     = gnt_q;
        gnt_vld = (state_q == GRANT);
    end

endmodule

// File: tb/tb_arbiter_round_robin.sv
// tb/tb_arbiter_round_robin.sv - scoreboard bench for arbiter_round_robin

module tb_arbiter_round_robin;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] req = '0;
    logic [W-1:0] gnt;
    logic         gnt_vld;
    logic         gnt_rdy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected grants, pushed by the reference model as it issues them
    logic [W-1:0] exp_q[$];

    // Fairness window control, driven by stimulus
    logic fair_en  = 1'b0;
    int   fair_bit = 0;

    arbiter_round_robin #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_rdy (gnt_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: rotating priority, pointer = winner + 1 on acceptance.
    int m_ptr  = 0;
    bit m_busy = 1'b0;
    int m_idx  = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ptr  = 0;
                m_busy = 1'b0;
                exp_q.delete();
            end else begin
                if (m_busy && gnt_rdy) begin
                    m_ptr  = (m_idx + 1) % W;
                    m_busy = 1'b0;
                end
                if (!m_busy) begin
                    for (int k = 0; k < W; k++) begin
                        int j;
                        j = (m_ptr + k) % W;
                        if (!m_busy && req[j]) begin
                            m_busy = 1'b1;
                            m_idx  = j;
                            exp_q.push_back(W'(1 << j));
                        end
                    end
                end
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each handshake.
    initial begin
        logic [W-1:0] prev_gnt;
        logic         prev_hold;
        logic         prev_fair;
        int           fair_cnt;
        logic [W-1:0] e;
        prev_gnt  = '0;
        prev_hold = 1'b0;
        prev_fair = 1'b0;
        fair_cnt  = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("vld_vs_model", gnt_vld, exp_q.size() != 0);
            chk("onehot0", $onehot0(gnt), 1);
            chk("vld_eq_or", gnt_vld, |gnt);
            if (prev_hold) begin
                chk("stable_stall", gnt, prev_gnt);
            end
            if (fair_en && !prev_fair) begin
                fair_cnt = 0;
            end
            if (gnt_vld && gnt_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", gnt, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_grant", gnt, e);
                end
                if (fair_en) begin
                    if (gnt[fair_bit]) begin
                        fair_cnt = 0;
                    end else begin
                        fair_cnt++;
                    end
                    chk("fair_bound", fair_cnt < W, 1);
                end
            end
            prev_gnt  = gnt;
            prev_hold = gnt_vld && !gnt_rdy && !rst;
            prev_fair = fair_en;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        gnt_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_gnt", gnt, 0);
        chk("reset_vld", gnt_vld, 0);

        // Two requesters alternate, pointer 0 -> 2 -> 0
        req = 4'b1010;
        gnt_rdy = 1'b1;
        tick(); chk("alt_c1", gnt, 4'b0010);
        tick(); chk("alt_c2", gnt, 4'b1000);
        tick(); chk("alt_c3", gnt, 4'b0010);

        // All request: one grant per cycle in rotation
        do_reset();
        req = 4'b1111;
        gnt_rdy = 1'b1;
        tick(); chk("all_g0", gnt, 4'b0001); chk("all_v0", gnt_vld, 1);
        tick(); chk("all_g1", gnt, 4'b0010); chk("all_v1", gnt_vld, 1);
        tick(); chk("all_g2", gnt, 4'b0100); chk("all_v2", gnt_vld, 1);
        tick(); chk("all_g3", gnt, 4'b1000); chk("all_v3", gnt_vld, 1);
        tick(); chk("all_g4", gnt, 4'b0001); chk("all_v4", gnt_vld, 1);

        // Wrap: after 0100 is accepted, pointer 3, only low bits requesting
        do_reset();
        req = 4'b1111;
        gnt_rdy = 1'b1;
        tick(); tick(); tick();
        chk("wrap_pre", gnt, 4'b0100);
        req = 4'b0011;
        tick(); chk("wrap_g0", gnt, 4'b0001);
        tick(); chk("wrap_g1", gnt, 4'b0010);

        // Backpressure with toggling req, including withdrawal of req[2]
        do_reset();
        req = 4'b0100;
        gnt_rdy = 1'b0;
        tick(); chk("bp_first", gnt, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            req = (i == 2) ? 4'b0000 : W'($urandom) & 4'b1011;
            tick();
            chk("bp_hold", gnt, 4'b0100);
        end
        gnt_rdy = 1'b1;
        req = 4'b0000;
        tick(); chk("bp_drop_g", gnt, 0); chk("bp_drop_v", gnt_vld, 0);
        gnt_rdy = $urandom_range(0, 1) != 0;
        tick(); chk("idle_rdy_ignored", gnt_vld, 0);
        req = 4'b1111;
        tick(); chk("bp_ptr3", gnt, 4'b1000);

        // Reset overriding a simultaneous handshake
        do_reset();
        req = 4'b1000;
        gnt_rdy = 1'b1;
        tick(); chk("rst_pre", gnt, 4'b1000);
        rst = 1'b1;
        req = 4'b1111;
        tick(); chk("rst_mid_g", gnt, 0); chk("rst_mid_v", gnt_vld, 0);
        rst = 1'b0;
        req = 4'b1001;
        tick(); chk("rst_after", gnt, 4'b0001);

        // Random run with periodic fairness windows
        for (int c = 0; c < 12000; c++) begin
            if (c % 1000 == 500) begin
                fair_bit = $urandom_range(0, W - 1);
                rst = 1'b0;
                gnt_rdy = 1'b1;
                for (int t = 0; t < 40; t++) begin
                    req = W'($urandom) | W'(1 << fair_bit);
                    if (t == 2) fair_en = 1'b1;
                    tick();
                end
                fair_en = 1'b0;
            end else begin
                rst = ($urandom_range(0, 499) == 0);
                req = W'($urandom);
                gnt_rdy = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        rst = 1'b0;
        req = '0;
        gnt_rdy = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
